// File: rtl/alu_pkg.sv
// Shared definitions for the ALU signed arithmetic unit: divider FSM states,
// default operand width and the divide-by-zero quotient pattern.
package alu_pkg;

   localparam int unsigned DEFAULT_WIDTH = 32;

   // All ones (-1 in two's complement); sliced to the operand width by users.
   localparam logic [63:0] DBZ_QUOTIENT = '1;

   typedef enum logic [1:0] {
      IDLE,
      PREP,
      ITER,
      FIX
   } state_t;

endpackage

// File: rtl/sdiv_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, keep the difference if non-negative.
module sdiv_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH:0] rem,
   input  logic           dvd_msb,
   input  logic [WIDTH:0] divisor,
   output logic [WIDTH:0] rem_next,
   output logic           q_bit
);

   logic [WIDTH+1:0] diff;

   always_comb begin
      diff     = {rem, dvd_msb} - {1'b0, divisor};
      q_bit    = ~diff[WIDTH+1];
      rem_next = q_bit ? diff[WIDTH:0] : {rem[WIDTH-1:0], dvd_msb};
   end

endmodule

// File: rtl/sdiv_seq.sv
// Multi-cycle signed divider: magnitudes are divided by one restoring step per
// cycle, then signs are applied so the remainder follows the dividend.
module sdiv_seq
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Quotient,
   output logic [WIDTH-1:0] Remainder,
   output logic             div_by_zero
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_r, b_r, dvd;
   logic [WIDTH:0]   rem, dsr, rem_step;
   logic             q_bit, s_a, s_q, dbz;
   logic [CW-1:0]    cnt;

   sdiv_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem),
      .dvd_msb  (dvd[WIDTH-1]),
      .divisor  (dsr),
      .rem_next (rem_step),
      .q_bit    (q_bit)
   );

   assign busy = (state != IDLE);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start) state_nxt = PREP;
         PREP: state_nxt = (b_r == '0) ? FIX : ITER;
         ITER: if (cnt == LAST) state_nxt = FIX;
         FIX:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // done is registered on the FIX exit edge, so it lands in the IDLE cycle
   // together with the new results and never overlaps busy.
   always_ff @(posedge clk) begin
      if (reset) begin
         a_r         <= '0;
         b_r         <= '0;
         dvd         <= '0;
         rem         <= '0;
         dsr         <= '0;
         s_a         <= 1'b0;
         s_q         <= 1'b0;
         dbz         <= 1'b0;
         cnt         <= '0;
         done        <= 1'b0;
         Quotient    <= '0;
         Remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_r <= A;
                  b_r <= B;
               end
            end
            PREP: begin
               dbz <= (b_r == '0);
               s_a <= a_r[WIDTH-1];
               s_q <= a_r[WIDTH-1] ^ b_r[WIDTH-1];
               dvd <= a_r[WIDTH-1] ? -a_r : a_r;
               dsr <= b_r[WIDTH-1] ? -{1'b1, b_r} : {1'b0, b_r};
               rem <= '0;
               cnt <= '0;
            end
            ITER: begin
               rem <= rem_step;
               dvd <= {dvd[WIDTH-2:0], q_bit};
               cnt <= cnt + CW'(1);
            end
            FIX: begin
               done        <= 1'b1;
               div_by_zero <= dbz;
               if (dbz) begin
                  Quotient  <= DBZ_QUOTIENT[WIDTH-1:0];
                  Remainder <= a_r;
               end else begin
                  Quotient  <= s_q ? -dvd : dvd;
                  Remainder <= s_a ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sdiv_seq.sv
// Bench for sdiv_seq: arithmetic reference model checked every cycle, plus
// directed vectors with literal expected results and latencies.
module tb_sdiv_seq;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic        busy, done, div_by_zero;
   logic [31:0] Quotient, Remainder;

   int checks = 0;
   int passes = 0;
   int cyc = 0;
   int e0 = 0;

   sdiv_seq #(.WIDTH(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .A           (A),
      .B           (B),
      .busy        (busy),
      .done        (done),
      .Quotient    (Quotient),
      .Remainder   (Remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s at cycle %0d: got %h, required %h", name, cyc, act, exp);
   endtask

   function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] q, output logic [31:0] r,
                                 output logic d);
      longint la, lb;
      la = longint'($signed(a));
      lb = longint'($signed(b));
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
         d = 1'b1;
      end else begin
         q = 32'(la / lb);
         r = 32'(la % lb);
         d = 1'b0;
      end
   endfunction

   // Reference: one operation in flight, finishing 34 edges (2 for B=0) after acceptance.
   bit          m_busy = 1'b0;
   int          due = -1;
   logic [31:0] eq = '0, er = '0, pq = '0, pr = '0;
   logic        edbz = 1'b0, pdbz = 1'b0;

   always @(posedge clk) begin
      cyc++;
      if (reset) begin
         m_busy = 1'b0;
         due    = -1;
         eq     = '0;
         er     = '0;
         edbz   = 1'b0;
      end else if (m_busy) begin
         if (cyc == due) begin
            m_busy = 1'b0;
            eq     = pq;
            er     = pr;
            edbz   = pdbz;
         end
      end else if (start) begin
         m_busy = 1'b1;
         model(A, B, pq, pr, pdbz);
         due = cyc + ((B == 32'd0) ? 2 : 34);
      end
   end

   always @(negedge clk) begin
      if (cyc > 0) begin
         chk("busy", {31'd0, busy}, {31'd0, m_busy});
         chk("done", {31'd0, done}, {31'd0, (due >= 0 && cyc == due)});
         chk("quotient", Quotient, eq);
         chk("remainder", Remainder, er);
         chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, edbz});
      end
   end

   task automatic issue_now(input logic [31:0] a, input logic [31:0] b);
      A = a;
      B = b;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      e0 = cyc;
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      issue_now(a, b);
   endtask

   task automatic wait_done(output int lat);
      lat = -1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            lat = cyc - e0;
            break;
         end
      end
   endtask

   task automatic expect_result(input string name, input int lat, input int exp_lat,
                                input logic [31:0] q, input logic [31:0] r, input logic d);
      chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
      chk({name, "_Q"}, Quotient, q);
      chk({name, "_R"}, Remainder, r);
      chk({name, "_dbz"}, {31'd0, div_by_zero}, {31'd0, d});
   endtask

   task automatic run(input string name, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] q, input logic [31:0] r, input logic d,
                      input int exp_lat);
      int lat;
      issue(a, b);
      wait_done(lat);
      expect_result(name, lat, exp_lat, q, r, d);
   endtask

   initial begin
      int  lat;
      bit  seen;
      repeat (3) @(negedge clk);
      chk("reset_Q", Quotient, 32'd0);
      chk("reset_R", Remainder, 32'd0);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      reset = 1'b0;

      run("pos_pos", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34);
      run("neg_pos", -32'sd100, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 34);
      run("pos_neg", 32'd100, -32'sd7, 32'hFFFF_FFF2, 32'd2, 1'b0, 34);
      run("neg_neg", -32'sd100, -32'sd7, 32'd14, 32'hFFFF_FFFE, 1'b0, 34);
      run("min_by_m1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 34);
      run("min_by_3", 32'h8000_0000, 32'd3, 32'hD555_5556, 32'hFFFF_FFFE, 1'b0, 34);
      run("dbz", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 2);
      run("after_dbz", 32'd6, 32'd3, 32'd2, 32'd0, 1'b0, 34);

      // start pulsed mid-operation must be ignored
      issue(32'd9, 32'd2);
      repeat (9) @(negedge clk);
      A = 32'd50;
      B = 32'd5;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(lat);
      expect_result("ignored_start", lat, 34, 32'd4, 32'd1, 1'b0);

      // back-to-back start in the done cycle
      issue_now(32'd50, 32'd5);
      wait_done(lat);
      expect_result("back_to_back", lat, 34, 32'd10, 32'd0, 1'b0);

      // reset mid-operation
      issue(32'd1000, 32'd3);
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midreset_Q", Quotient, 32'd0);
      chk("midreset_R", Remainder, 32'd0);
      chk("midreset_busy", {31'd0, busy}, 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1'b1;
      end
      chk("midreset_no_done", {31'd0, seen}, 32'd0);
      run("after_reset", 32'd7, 32'd7, 32'd1, 32'd0, 1'b0, 34);

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/sdiv_seq.md
# sdiv_seq

Multi-cycle signed integer divider: the inverse of the signed multiply path in the ALU's signed arithmetic unit. It accepts a dividend/divisor pair through a start/busy/done handshake and runs one restoring-division step per cycle. It returns a truncated (round-toward-zero) quotient and remainder plus a divide-by-zero flag. It lets the ALU drop the combinational divider from the critical path; the ALU control stalls on `busy` and latches results on `done`.

## Interface
- `WIDTH`, 32: operand and result width in bits (two's complement).
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request; sampled only when `busy`=0.
- `A`  in  WIDTH  dividend (signed); sampled on the accepting edge.
- `B`  in  WIDTH  divisor (signed); sampled on the accepting edge.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse; results are valid from this cycle onward.
- `Quotient`  out  WIDTH  signed quotient, registered.
- `Remainder`  out  WIDTH  signed remainder, registered.
- `div_by_zero`  out  1  set with `done` when `B`=0; held with the results.

## Operation
- States:
  - IDLE: wait for `start`.
  - PREP:
    - If `B`=0, go to FIX with the dbz flag set.
    - Otherwise load |A| into the dividend shift register, |B| into the divisor register, and clear the partial remainder.
    - Record `sA`=A[msb] and `sQ`=A[msb]^B[msb].
  - ITER: WIDTH cycles of restoring division.
    - Shift {rem,dvd} left 1.
    - Trial-subtract the divisor from rem.
    - If the result is non-negative, keep it and set the quotient bit; otherwise restore the old rem.
    - A step counter runs 0..WIDTH-1; go to FIX after step WIDTH-1.
  - FIX: write the output registers, pulse `done`, return to IDLE.
- Sign rules at FIX:
  - Quotient is negated when `sQ`=1.
  - Remainder is negated when `sA`=1, so the remainder takes the dividend's sign.
  - These rules give A = Q·B + R with |R| < |B|.
- Width rules:
  - Absolute values are computed in WIDTH+1 bits, so |MIN| = 2^(WIDTH-1) is exact.
  - The partial remainder is WIDTH+1 bits.
  - Results are truncated to WIDTH bits.
  - MIN / −1 therefore yields Q=MIN (wraps) and R=0. No overflow flag.
- Divide by zero: Q = all ones (−1), R = A unchanged, `div_by_zero`=1.
- `start` while `busy`=1 is ignored. The operands are not re-sampled and there is no queueing.
- `start` in the same cycle as `done` is accepted, since the state is IDLE that cycle.
- Outputs hold their last values until the next `done` overwrites them.

## Timing
- Reset (any state, including mid-operation): state=IDLE, `busy`=0, `done`=0, `Quotient`=0, `Remainder`=0, `div_by_zero`=0, counter=0. The in-flight operation is discarded and no `done` is produced.
- Accepting edge E0: `busy`=1 from the cycle after E0.
- Normal latency: `done`=1 in the cycle after edge E0+WIDTH+2, which is 34 edges for WIDTH=32. `busy`=0 in that same cycle.
- Divide-by-zero latency: `done` after edge E0+2 (PREP→FIX).
- `done` is exactly one cycle wide. `busy` and `done` are never high together.

## Structure
- Shared package `alu_pkg` holds:
  - The state encoding (IDLE, PREP, ITER, FIX).
  - The default `WIDTH`.
  - The divide-by-zero quotient constant (all ones).
- Sub-module `sdiv_step`: a combinational single restoring step.
  - Inputs: rem, dvd MSB, divisor.
  - Outputs: new rem, quotient bit.
  - It is instantiated once in ITER; the FSM, counter and sign fix live in `sdiv_seq`.

## Test plan
- A=100, B=7, start at E0 → `done` after E0+34; Q=14, R=2, dbz=0.
- Sign cases:
  - A=−100, B=7 → Q=−14 (0xFFFFFFF2), R=−2.
  - A=100, B=−7 → Q=−14, R=2.
  - A=−100, B=−7 → Q=14, R=−2.
- Overflow: A=0x80000000, B=0xFFFFFFFF → Q=0x80000000, R=0, dbz=0.
- Divide by zero: A=5, B=0 → `done` after E0+2 with Q=0xFFFFFFFF, R=5, dbz=1. A following 6/3 clears dbz (Q=2, R=0).
- Ignored start: start 9/2, then pulse `start` with 50/5 at E0+10 → the only result is Q=4, R=1. A back-to-back start in the `done` cycle → the next `done` arrives 34 edges later.
- Reset mid-operation: assert `reset` at E0+10 → all outputs 0, no `done` within 40 cycles. The next 7/7 completes normally with Q=1, R=0.
